// File: rtl/exec_mdu_ctrl_pkg.sv
// exec_mdu_ctrl_pkg: shared definitions for the iterative RV32M multiply/divide
// sequencer in the Execute stage.
//   XLEN_DEF / CNT_W_DEF : default operand width and iteration counter width
//   MD_*                 : funct3 encodings of the M-extension ops
//   mdState_t            : sequencer state (IDLE -> BUSY -> DONE -> IDLE)
package exec_mdu_ctrl_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CNT_W_DEF = 6;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mdState_t;

endpackage

// File: rtl/exec_mdu_ctrl_if.sv
// exec_mdu_ctrl_if: Execute-stage <-> multiply/divide unit signal bundle.
//   master : pipeline side, drives MDStartE/MDOpE/SrcAE/SrcBE/KillE,
//            observes StallMD/MDValidE/MDResultE/MDBusy
//   slave  : the MDU sequencer, the mirror image
interface exec_mdu_ctrl_if
  import exec_mdu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);

  logic            MDStartE;
  logic [2:0]      MDOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            KillE;
  logic            StallMD;
  logic            MDValidE;
  logic [XLEN-1:0] MDResultE;
  logic            MDBusy;

  modport master (
    output MDStartE, MDOpE, SrcAE, SrcBE, KillE,
    input  StallMD, MDValidE, MDResultE, MDBusy
  );

  modport slave (
    input  MDStartE, MDOpE, SrcAE, SrcBE, KillE,
    output StallMD, MDValidE, MDResultE, MDBusy
  );

endinterface

// File: rtl/exec_mdu_ctrl_step.sv
// mdu_iter_step: combinational single iteration of the MDU datapath.
//   isDiv    in  : 1 = restoring-division step, 0 = shift-add multiply step
//   hiIn     in  : multiply: upper product half / divide: partial remainder
//   loIn     in  : multiply: lower product half + remaining multiplier bits /
//                  divide: remaining dividend bits + quotient bits so far
//   operandB in  : multiplicand or divisor magnitude
//   hiOut/loOut  : register values after this iteration
module mdu_iter_step
  import exec_mdu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            isDiv,
  input  logic [XLEN-1:0] hiIn,
  input  logic [XLEN-1:0] loIn,
  input  logic [XLEN-1:0] operandB,
  output logic [XLEN-1:0] hiOut,
  output logic [XLEN-1:0] loOut
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    hiOut   = hiIn;
    loOut   = loIn;
    if (isDiv) begin
      // Remainder < divisor, so the shifted value fits in XLEN+1 bits and
      // the top bit of the difference is a clean borrow flag.
      shifted = {hiIn, loIn[XLEN-1]};
      diff    = shifted - {1'b0, operandB};
      if (!diff[XLEN]) begin
        hiOut = diff[XLEN-1:0];
        loOut = {loIn[XLEN-2:0], 1'b1};
      end else begin
        hiOut = shifted[XLEN-1:0];
        loOut = {loIn[XLEN-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, hiIn} + (loIn[0] ? {1'b0, operandB} : '0);
      hiOut = sum[XLEN:1];
      loOut = {sum[0], loIn[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/exec_mdu_ctrl.sv
// exec_mdu_ctrl: sequencer for the iterative RV32M multiply/divide unit in E.
//   clk  in : clock, rising edge
//   rst  in : synchronous reset, active-low
//   md      : slave side of exec_mdu_ctrl_if
//     MDStartE/MDOpE/SrcAE/SrcBE/KillE in ; StallMD/MDValidE/MDResultE/MDBusy out
// An accepted op runs one bit per cycle for XLEN cycles (1 cycle for the
// divide-by-zero / signed-overflow cases), then presents the result for one
// cycle in DONE. StallMD holds F/D/E while the op is in flight.
module exec_mdu_ctrl
  import exec_mdu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  exec_mdu_ctrl_if.slave md
);

  mdState_t         stateQ;
  logic [CNT_W-1:0] cntQ;
  logic [2:0]       opQ;
  logic             negQ;
  logic             specialQ;
  logic [XLEN-1:0]  hiQ;
  logic [XLEN-1:0]  loQ;
  logic [XLEN-1:0]  opBQ;
  logic [XLEN-1:0]  resultQ;

  // Accept-cycle decode
  logic            aSigned, bSigned, signA, signB;
  logic [XLEN-1:0] magA, magB;
  logic            negAcc;
  logic            divZero, divOvf;
  logic [XLEN-1:0] specialVal;

  always_comb begin
    aSigned = (md.MDOpE == MD_MULH) || (md.MDOpE == MD_MULHSU) ||
              (md.MDOpE == MD_DIV)  || (md.MDOpE == MD_REM);
    bSigned = (md.MDOpE == MD_MULH) || (md.MDOpE == MD_DIV) ||
              (md.MDOpE == MD_REM);
    signA   = aSigned & md.SrcAE[XLEN-1];
    signB   = bSigned & md.SrcBE[XLEN-1];
    magA    = signA ? -md.SrcAE : md.SrcAE;
    magB    = signB ? -md.SrcBE : md.SrcBE;
    // Remainder follows the dividend; everything else follows sign parity.
    negAcc  = (md.MDOpE == MD_REM) ? signA : (signA ^ signB);
    divZero = md.MDOpE[2] && (md.SrcBE == '0);
    divOvf  = ((md.MDOpE == MD_DIV) || (md.MDOpE == MD_REM)) &&
              (md.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (md.SrcBE == '1);
    specialVal = '0;
    if (divZero)     specialVal = md.MDOpE[1] ? md.SrcAE : '1;
    else if (divOvf) specialVal = md.MDOpE[1] ? '0 : md.SrcAE;
  end

  // One datapath iteration and final sign fix-up
  logic [XLEN-1:0]   hiN, loN;
  logic [2*XLEN-1:0] prod, prodFix;
  logic [XLEN-1:0]   finalVal;

  mdu_iter_step #(.XLEN(XLEN)) uStep (
    .isDiv    (opQ[2]),
    .hiIn     (hiQ),
    .loIn     (loQ),
    .operandB (opBQ),
    .hiOut    (hiN),
    .loOut    (loN)
  );

  always_comb begin
    prod     = {hiN, loN};
    prodFix  = negQ ? -prod : prod;
    finalVal = '0;
    if (specialQ) begin
      finalVal = hiQ;
    end else begin
      case (opQ)
        MD_MUL:                     finalVal = prodFix[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: finalVal = prodFix[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:            finalVal = negQ ? -loN : loN;
        default:                    finalVal = negQ ? -hiN : hiN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ   <= S_IDLE;
      cntQ     <= '0;
      opQ      <= '0;
      negQ     <= 1'b0;
      specialQ <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
      opBQ     <= '0;
      resultQ  <= '0;
    end else if (md.KillE) begin
      stateQ <= S_IDLE;
      cntQ   <= '0;
    end else begin
      case (stateQ)
        S_IDLE: begin
          if (md.MDStartE) begin
            opQ      <= md.MDOpE;
            negQ     <= negAcc;
            specialQ <= divZero | divOvf;
            // Special cases park their answer in hiQ and skip iteration.
            hiQ      <= (divZero | divOvf) ? specialVal : '0;
            loQ      <= magA;
            opBQ     <= magB;
            cntQ     <= (divZero | divOvf) ? CNT_W'(1) : CNT_W'(XLEN);
            stateQ   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!specialQ) begin
            hiQ <= hiN;
            loQ <= loN;
          end
          if (cntQ != '0) cntQ <= cntQ - 1'b1;
          if (cntQ <= CNT_W'(1)) begin
            resultQ <= finalVal;
            stateQ  <= S_DONE;
          end
        end
        S_DONE:  stateQ <= S_IDLE;
        default: stateQ <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    md.StallMD   = !md.KillE &&
                   (((stateQ == S_IDLE) && md.MDStartE) || (stateQ == S_BUSY));
    md.MDValidE  = (stateQ == S_DONE) && !md.KillE;
    md.MDResultE = md.MDValidE ? resultQ : '0;
    md.MDBusy    = (stateQ != S_IDLE);
  end

endmodule
